// File: rtl/thermal_rx_meter.sv
// thermal_rx_meter: counts ring-oscillator edges over fixed windows, slices
// each window count into a thermal symbol, packs symbols into bytes and pages
// the latest count onto an LED bank behind a blank lead-in page.
// Optional feature macro: THERM_PEAK_EN (running maximum on peak_count).
module thermal_rx_meter #(
  parameter int COUNT_W       = 20,
  parameter int WINDOW_CYCLES = 1000000,
  parameter int LED_W         = 8,
  parameter int PAGE_SHIFT    = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ro_in,
  input  logic [COUNT_W-1:0] threshold,
  output logic [COUNT_W-1:0] meas_count,
  output logic               meas_valid,
  output logic               rx_bit,
  output logic [7:0]         rx_byte,
  output logic               rx_byte_valid,
  output logic               overflow,
  output logic [COUNT_W-1:0] peak_count,
  output logic [LED_W-1:0]   led
);

  localparam int NPAGES = (COUNT_W + LED_W - 1) / LED_W;
  localparam int PAD_W  = NPAGES * LED_W;
  localparam int WIN_W  = $clog2(WINDOW_CYCLES);
  localparam int PIDX_W = (NPAGES > 1) ? $clog2(NPAGES) : 1;

  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [PIDX_W-1:0]  PIDX_LAST = PIDX_W'(NPAGES - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    ST_BLANK,
    ST_PAGE
  } dispState_t;

  logic               syncMeta_q, syncOut_q, syncDly_q;
  logic               roEdge;
  logic [WIN_W-1:0]   winCnt_q;
  logic               winEnd;
  logic [COUNT_W-1:0] edgeCnt_q, edgeCnt_d;
  logic               symbol;
  logic [COUNT_W-1:0] measCount_q;
  logic               measValid_q, rxBit_q, overflow_q;
  logic [6:0]         shift_q;
  logic [7:0]         shift_d;
  logic [2:0]         bitIdx_q;
  logic [7:0]         rxByte_q;
  logic               rxByteValid_q;
  dispState_t         dispState_q;
  logic [PIDX_W-1:0]  pageIdx_q;
  logic [PAGE_SHIFT-1:0] pageTimer_q;
  logic               pageWrap;
  logic [PAD_W-1:0]   paddedCount;
  logic [LED_W-1:0]   pageVal;
  logic [LED_W-1:0]   led_q;

  // Bring the asynchronous tap into the clk domain and keep a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
      syncDly_q  <= 1'b0;
    end else begin
      syncMeta_q <= ro_in;
      syncOut_q  <= syncMeta_q;
      syncDly_q  <= syncOut_q;
    end
  end

  assign roEdge = syncOut_q & ~syncDly_q;
  assign winEnd = (winCnt_q == WIN_LAST);

  // Saturating count including this cycle's edge; the symbol and next shift value derive from it
  always_comb begin
    edgeCnt_d = edgeCnt_q;
    if (roEdge && (edgeCnt_q != CNT_MAX)) begin
      edgeCnt_d = edgeCnt_q + 1'b1;
    end
    symbol  = (edgeCnt_d >= threshold);
    shift_d = {shift_q, symbol};
  end

  // Window timer and edge counter; both restart together on the terminal cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      winCnt_q  <= '0;
      edgeCnt_q <= '0;
    end else if (winEnd) begin
      winCnt_q  <= '0;
      edgeCnt_q <= '0;
    end else begin
      winCnt_q  <= winCnt_q + 1'b1;
      edgeCnt_q <= edgeCnt_d;
    end
  end

  // Latch the finished window; saturation is sticky, so a final count of all-ones means it saturated
  always_ff @(posedge clk) begin
    if (rst) begin
      measCount_q <= '0;
      measValid_q <= 1'b0;
      rxBit_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      measValid_q <= winEnd;
      if (winEnd) begin
        measCount_q <= edgeCnt_d;
        overflow_q  <= (edgeCnt_d == CNT_MAX);
        rxBit_q     <= symbol;
      end
    end
  end

  // Pack symbols MSB-first in arrival order; the eighth symbol goes straight into rx_byte
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q       <= '0;
      bitIdx_q      <= '0;
      rxByte_q      <= '0;
      rxByteValid_q <= 1'b0;
    end else begin
      rxByteValid_q <= 1'b0;
      if (winEnd) begin
        shift_q <= shift_d[6:0];
        if (bitIdx_q == 3'd7) begin
          rxByte_q      <= shift_d;
          rxByteValid_q <= 1'b1;
          bitIdx_q      <= '0;
        end else begin
          bitIdx_q <= bitIdx_q + 1'b1;
        end
      end
    end
  end

  assign pageWrap    = &pageTimer_q;
  assign paddedCount = PAD_W'(measCount_q);
  assign pageVal     = paddedCount[int'(pageIdx_q) * LED_W +: LED_W];

  // Display pager: blank lead-in, then each LED-wide slice of the count, advancing on timer wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      dispState_q <= ST_BLANK;
      pageIdx_q   <= '0;
      pageTimer_q <= '0;
      led_q       <= '0;
    end else begin
      pageTimer_q <= pageTimer_q + 1'b1;
      led_q       <= (dispState_q == ST_PAGE) ? pageVal : '0;
      if (pageWrap) begin
        case (dispState_q)
          ST_BLANK: begin
            dispState_q <= ST_PAGE;
            pageIdx_q   <= '0;
          end
          ST_PAGE: begin
            if (pageIdx_q == PIDX_LAST) begin
              dispState_q <= ST_BLANK;
              pageIdx_q   <= '0;
            end else begin
              pageIdx_q <= pageIdx_q + 1'b1;
            end
          end
          default: begin
            dispState_q <= ST_BLANK;
            pageIdx_q   <= '0;
          end
        endcase
      end
    end
  end

`ifdef THERM_PEAK_EN
  logic [COUNT_W-1:0] peak_q;

  // Running maximum of completed window counts, updated alongside meas_count
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
    end else if (winEnd && (edgeCnt_d > peak_q)) begin
      peak_q <= edgeCnt_d;
    end
  end

  assign peak_count = peak_q;
`else
  assign peak_count = '0;
`endif

  assign meas_count    = measCount_q;
  assign meas_valid    = measValid_q;
  assign rx_bit        = rxBit_q;
  assign rx_byte       = rxByte_q;
  assign rx_byte_valid = rxByteValid_q;
  assign overflow      = overflow_q;
  assign led           = led_q;

endmodule

// File: tb/tb_thermal_rx_meter.sv
// Testbench for thermal_rx_meter: two instances (8-bit and 3-bit counters)
// share one stimulus stream; a negedge monitor checks them against queued
// expectations and a page-position model of the LED bank.
module tb_thermal_rx_meter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       roIn = 1'b0;
  logic [7:0] threshold = 8'd0;

  logic [7:0] measCount, rxByte, peakCount;
  logic       measValid, rxBit, rxByteValid, overflow;
  logic [3:0] led;

  logic [2:0] measCount3, peakCount3;
  logic [7:0] rxByte3;
  logic       measValid3, rxBit3, rxByteValid3, overflow3;
  logic [3:0] led3;

  typedef struct {
    logic [7:0] cnt;
    logic       ovf;
    logic       bitv;
    logic [7:0] peak;
    int         cyc;
  } measExp_t;

  measExp_t   expQ[$];
  measExp_t   expQ3[$];
  logic [7:0] byteQ[$];
  logic [7:0] byteQ3[$];

  int checks = 0;
  int passes = 0;
  int posCnt = 0;
  int sinceRst = 0;
  logic [7:0] peakM = 8'd0;
  logic [2:0] peakM3 = 3'd0;
  logic [7:0] mcNow = 8'd0;
  logic [2:0] mcNow3 = 3'd0;

  thermal_rx_meter #(.COUNT_W(8), .WINDOW_CYCLES(16), .LED_W(4), .PAGE_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .ro_in(roIn), .threshold(threshold),
    .meas_count(measCount), .meas_valid(measValid), .rx_bit(rxBit),
    .rx_byte(rxByte), .rx_byte_valid(rxByteValid), .overflow(overflow),
    .peak_count(peakCount), .led(led)
  );

  thermal_rx_meter #(.COUNT_W(3), .WINDOW_CYCLES(16), .LED_W(4), .PAGE_SHIFT(2)) dut3 (
    .clk(clk), .rst(rst), .ro_in(roIn), .threshold(threshold[2:0]),
    .meas_count(measCount3), .meas_valid(measValid3), .rx_bit(rxBit3),
    .rx_byte(rxByte3), .rx_byte_valid(rxByteValid3), .overflow(overflow3),
    .peak_count(peakCount3), .led(led3)
  );

  // Free-running clock
  initial forever #5 clk = ~clk;

  // Cycle bookkeeping: total posedges and posedges since the last reset cycle
  always @(posedge clk) begin
    posCnt <= posCnt + 1;
    if (rst) sinceRst <= 0;
    else     sinceRst <= sinceRst + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic int countRises(input logic [15:0] pat);
    int n = 0;
    for (int j = 0; j < 14; j++) begin
      if (pat[j] && (j == 0 || !pat[j-1])) n++;
    end
    return n;
  endfunction

  function automatic logic [15:0] edgesPat(input int n);
    logic [15:0] p = 16'h0000;
    for (int i = 0; i < n; i++) p[2*i] = 1'b1;
    return p;
  endfunction

  // One full window: queue what both instances must report, then play the pattern
  task automatic applyStimulus(input logic [15:0] pat, input logic [7:0] thr);
    measExp_t e, e3;
    int n = countRises(pat);
    e.cnt  = 8'(n);
    e.ovf  = 1'b0;
    e.bitv = (8'(n) >= thr);
    e.cyc  = posCnt + 16;
    e3.cnt  = (n >= 7) ? 8'd7 : 8'(n);
    e3.ovf  = (n >= 7);
    e3.bitv = (e3.cnt[2:0] >= thr[2:0]);
    e3.cyc  = posCnt + 16;
`ifdef THERM_PEAK_EN
    if (e.cnt > peakM) peakM = e.cnt;
    if (e3.cnt[2:0] > peakM3) peakM3 = e3.cnt[2:0];
    e.peak  = peakM;
    e3.peak = {5'd0, peakM3};
`else
    e.peak  = 8'd0;
    e3.peak = 8'd0;
`endif
    expQ.push_back(e);
    expQ3.push_back(e3);
    threshold = thr;
    for (int j = 0; j < 16; j++) begin
      roIn = pat[j];
      @(negedge clk);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst meas_count", measCount, 0);
    checkOutput("rst meas_valid", measValid, 0);
    checkOutput("rst rx_bit", rxBit, 0);
    checkOutput("rst rx_byte", rxByte, 0);
    checkOutput("rst rx_byte_valid", rxByteValid, 0);
    checkOutput("rst overflow", overflow, 0);
    checkOutput("rst peak_count", peakCount, 0);
    checkOutput("rst led", led, 0);
    checkOutput("rst3 meas_count", measCount3, 0);
    checkOutput("rst3 overflow", overflow3, 0);
    checkOutput("rst3 rx_byte", rxByte3, 0);
    checkOutput("rst3 led", led3, 0);
  endtask

  // Monitor: LED page model every cycle, scoreboard pops on each valid pulse
  always @(negedge clk) begin
    measExp_t   e;
    logic [7:0] b;
    int         k;
    int         s;
    logic [3:0] expLed;
    if (sinceRst == 0) begin
      mcNow  = 8'd0;
      mcNow3 = 3'd0;
    end else begin
      k = sinceRst - 1;
      s = (k / 4) % 3;
      expLed = (s == 0) ? 4'd0 : (s == 1) ? mcNow[3:0] : mcNow[7:4];
      checkOutput("led", led, expLed);
      s = (k / 4) % 2;
      expLed = (s == 0) ? 4'd0 : {1'b0, mcNow3};
      checkOutput("led3", led3, expLed);
    end
    if (measValid) begin
      if (expQ.size() == 0) checkOutput("unexpected meas_valid", 1, 0);
      else begin
        e = expQ.pop_front();
        checkOutput("meas_count", measCount, e.cnt);
        checkOutput("overflow", overflow, e.ovf);
        checkOutput("rx_bit", rxBit, e.bitv);
        checkOutput("peak_count", peakCount, e.peak);
        checkOutput("meas_valid cycle", posCnt, e.cyc);
        mcNow = e.cnt;
      end
    end
    if (measValid3) begin
      if (expQ3.size() == 0) checkOutput("unexpected meas_valid3", 1, 0);
      else begin
        e = expQ3.pop_front();
        checkOutput("meas_count3", measCount3, e.cnt);
        checkOutput("overflow3", overflow3, e.ovf);
        checkOutput("rx_bit3", rxBit3, e.bitv);
        checkOutput("peak_count3", peakCount3, e.peak);
        checkOutput("meas_valid3 cycle", posCnt, e.cyc);
        mcNow3 = e.cnt[2:0];
      end
    end
    if (rxByteValid) begin
      checkOutput("rx_byte_valid with meas_valid", measValid, 1);
      if (byteQ.size() == 0) checkOutput("unexpected rx_byte_valid", 1, 0);
      else begin
        b = byteQ.pop_front();
        checkOutput("rx_byte", rxByte, b);
      end
    end
    if (rxByteValid3) begin
      checkOutput("rx_byte_valid3 with meas_valid3", measValid3, 1);
      if (byteQ3.size() == 0) checkOutput("unexpected rx_byte_valid3", 1, 0);
      else begin
        b = byteQ3.pop_front();
        checkOutput("rx_byte3", rxByte3, b);
      end
    end
  end

  // Directed sequence
  initial begin
    logic [15:0] pat3;
    logic [7:0]  thrList [8];
    int          nList [8];
    repeat (3) @(negedge clk);
    checkReset();
    rst = 1'b0;

    // Alternating 5/1 edges against threshold 3, starting high
    byteQ.push_back(8'hAA);
    byteQ3.push_back(8'hAA);
    for (int i = 0; i < 8; i++) applyStimulus(edgesPat((i % 2 == 0) ? 5 : 1), 8'd3);

    // Square wave, period 4
    applyStimulus(16'h3333, 8'd3);
    applyStimulus(16'h3333, 8'd3);

    // Period-2 burst saturates the 3-bit instance, then a light window clears overflow
    applyStimulus(edgesPat(7), 8'd3);
    applyStimulus(edgesPat(2), 8'd3);

    // Reset at window cycle 9 after three counted edges
    pat3 = edgesPat(3);
    for (int j = 0; j < 9; j++) begin
      roIn = pat3[j];
      @(negedge clk);
    end
    rst  = 1'b1;
    roIn = 1'b0;
    @(negedge clk);
    checkReset();
    checkOutput("queue drained before reset", expQ.size() + expQ3.size(), 0);
    peakM  = 8'd0;
    peakM3 = 3'd0;
    rst = 1'b0;

    // Threshold boundaries and peak tracking; completes a second byte
    nList   = '{6, 7, 4, 2, 3, 0, 7, 1};
    thrList = '{8'd6, 8'd8, 8'd4, 8'd3, 8'd3, 8'd0, 8'd7, 8'd2};
    byteQ.push_back(8'hAE);
    byteQ3.push_back(8'hEE);
    for (int i = 0; i < 8; i++) applyStimulus(edgesPat(nList[i]), thrList[i]);

    repeat (3) @(negedge clk);
    checkOutput("meas queue empty", expQ.size(), 0);
    checkOutput("meas3 queue empty", expQ3.size(), 0);
    checkOutput("byte queue empty", byteQ.size(), 0);
    checkOutput("byte3 queue empty", byteQ3.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
